mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, multi-cycle data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access through a small FSM with a fixed number of wait states.
- Returns read data, and a one-cycle ready pulse, to the requester that was granted.
- Generates per-stage stall signals that the pipeline uses to freeze its stage registers while an access is outstanding.

Parameters:
- ADDR_W, 16, word-address width driven to the memory.
- WAIT_CYCLES, 4, memory access cycles per transaction; legal range is ≥1.
- MAX_DATA_STREAK, 2, number of consecutive data grants allowed while if_req waits, before fetch is forced a grant.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- if_stall  out  1  if_req & ~if_ready.
- d_r_en  in  1  load request; held until d_ready.
- d_w_en  in  1  store request; held until d_ready.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data port.
- d_stall  out  1  (d_r_en | d_w_en) & ~d_ready.
- ext_addr  out  ADDR_W  memory word address.
- ext_wdata  out  32  memory write data.
- ext_we  out  1  memory write strobe.
- ext_re  out  1  memory read strobe.
- ext_rdata  in  32  memory read data; valid in the last ACCESS cycle.

Behaviour:
- Reset (asynchronous; also takes effect mid-transaction):
  - State goes to IDLE; wait_cnt=0, streak=0.
  - All ext_* outputs are 0.
  - if_ready=0, d_ready=0; if_rdata=0, d_rdata=0.
  - A store aborted by reset leaves the addressed word undefined.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If a data request (d_r_en|d_w_en) is present and fetch is not owed, grant data.
  - Otherwise, if if_req is present, grant fetch.
  - Fetch is owed when streak==MAX_DATA_STREAK and if_req=1.
  - On a grant, latch owner, address, wdata and direction; set wait_cnt=WAIT_CYCLES-1; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - ext_addr = latched addr[ADDR_W+1:2]; byte offset bits are ignored.
  - ext_we=1 for a store, ext_re=1 for a read; the strobe is held stable for all WAIT_CYCLES cycles.
  - wait_cnt decrements each cycle.
  - When wait_cnt==0: capture ext_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - The owner's ready=1 for exactly this cycle; rdata is stable from this cycle until the next capture for that port.
  - Go to IDLE.
- Requester handshake:
  - The requester drops or changes its request in the cycle after ready.
  - A request still asserted in IDLE is treated as a new transaction.
- Latency: request in IDLE at cycle t → ready at cycle t+WAIT_CYCLES+1. The minimum turnaround between grants is WAIT_CYCLES+2 cycles.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, or on a data grant with if_req=0.
  - Saturates at MAX_DATA_STREAK.
- No preemption: a request that arrives during ACCESS or DONE waits in IDLE arbitration.
- Illegal input d_r_en & d_w_en together: handled as a store; d_rdata is not updated.
- Requests that change while not granted are ignored until the next IDLE sample.
- A store is signalled by d_ready only; d_rdata keeps its old value.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Owner encoding: OWN_IF=1'b0, OWN_D=1'b1.
- One sub-module, access_timer: a loadable down-counter with a zero flag, sized to $clog2(WAIT_CYCLES+1).
- Arbitration, latching and the FSM stay in the top module.

Test Plan:
- Single fetch, if_addr=0x0000_0008, ext_rdata model returns 0x2001_000A at word 2:
  - if_ready pulses at t+5, if_rdata=0x2001_000A.
  - ext_addr=2 and ext_re=1 for 4 cycles.
- Simultaneous if_req and d_r_en (d_addr=0x10):
  - Data is granted first, d_ready at t+5.
  - Fetch is granted in the next IDLE; if_ready at t+11.
  - if_stall=1 throughout, until if_ready.
- Store d_w_en, d_addr=0x24, d_wdata=0xDEAD_BEEF, then load from 0x24:
  - ext_we=1 with ext_addr=9 for 4 cycles.
  - The load returns 0xDEAD_BEEF; d_rdata is unchanged by the store.
- Starvation guard: hold if_req and issue back-to-back data requests:
  - Grant order is D, D, IF, D, D, IF; streak resets after each IF grant.
- Reset asserted in the 2nd ACCESS cycle of a store:
  - All outputs go to 0 immediately (asynchronously); state is IDLE.
  - After deassertion, a pending if_req is granted normally with 5-cycle latency.
- WAIT_CYCLES=1 build: request → ready in 2 cycles; the d_r_en & d_w_en case performs a store only.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// Loadable down-counter that measures the memory wait states of one access.
module access_timer #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle single-port memory between instruction fetch and
// load/store, with a starvation guard that forces a fetch after a data streak.
//
// state  | meaning
// IDLE   | arbitrate; latch owner, address, data and direction on a grant
// ACCESS | strobes held for WAIT_CYCLES cycles; read data captured in the last
// DONE   | owner's ready pulses for one cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int WAIT_CYCLES     = 4,
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_r_en,
    input  logic              d_w_en,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [31:0]       ext_wdata,
    output logic              ext_we,
    output logic              ext_re,
    input  logic [31:0]       ext_rdata
);

    localparam int CNT_W    = cnt_w(WAIT_CYCLES);
    localparam int STREAK_W = cnt_w(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0]    LP_LOAD       = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] LP_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    state_t              r_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic [31:0]         r_ext_wdata;
    logic                r_ext_we;
    logic                r_ext_re;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;
    logic                r_if_ready;
    logic                r_d_ready;
    logic [STREAK_W-1:0] r_streak;

    logic w_d_req;
    logic w_if_owed;
    logic w_grant_d;
    logic w_grant_if;
    logic w_tmr_zero;
    logic w_unused_addr_bits;

    assign w_d_req    = d_r_en | d_w_en;
    assign w_if_owed  = if_req & (r_streak == LP_STREAK_MAX);
    assign w_grant_d  = (r_state == IDLE) & w_d_req & ~w_if_owed;
    assign w_grant_if = (r_state == IDLE) & if_req & ~w_grant_d;

    // Byte offset and bits above the memory window are dropped on purpose.
    assign w_unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                  d_addr[31:ADDR_W+2], d_addr[1:0]};

    access_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_grant_d | w_grant_if),
        .i_load_val (LP_LOAD),
        .i_dec      (r_state == ACCESS),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_we    <= 1'b0;
            r_ext_re    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_streak    <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read+write request is treated as a store.
                        r_owner     <= OWN_D;
                        r_ext_addr  <= d_addr[ADDR_W+1:2];
                        r_ext_wdata <= d_w_en ? d_wdata : '0;
                        r_ext_we    <= d_w_en;
                        r_ext_re    <= ~d_w_en;
                        if (if_req) begin
                            r_streak <= (r_streak == LP_STREAK_MAX) ? LP_STREAK_MAX
                                                                    : r_streak + STREAK_W'(1);
                        end else begin
                            r_streak <= '0;
                        end
                        r_state <= ACCESS;
                    end else if (w_grant_if) begin
                        r_owner     <= OWN_IF;
                        r_ext_addr  <= if_addr[ADDR_W+1:2];
                        r_ext_wdata <= '0;
                        r_ext_we    <= 1'b0;
                        r_ext_re    <= 1'b1;
                        r_streak    <= '0;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_tmr_zero) begin
                        if (r_ext_re) begin
                            if (r_owner == OWN_D) begin
                                r_d_rdata <= ext_rdata;
                            end else begin
                                r_if_rdata <= ext_rdata;
                            end
                        end
                        if (r_owner == OWN_D) begin
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_ready <= 1'b1;
                        end
                        r_ext_we    <= 1'b0;
                        r_ext_re    <= 1'b0;
                        r_ext_addr  <= '0;
                        r_ext_wdata <= '0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign ext_addr  = r_ext_addr;
    assign ext_wdata = r_ext_wdata;
    assign ext_we    = r_ext_we;
    assign ext_re    = r_ext_re;
    assign if_stall  = if_req & ~r_if_ready;
    assign d_stall   = (d_r_en | d_w_en) & ~r_d_ready;

endmodule
